// File: rtl/vec_pkg.sv
// Shared types for the vector micro-op sequencer.
// Opcodes, FSM states, instruction fields and register codes.
package vec_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STORE = 3'd2,
    S_ALU   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam int OP_HI  = 8;
  localparam int OP_LO  = 7;
  localparam int REG_HI = 6;
  localparam int REG_LO = 5;
  localparam int BLK_HI = 4;
  localparam int BLK_LO = 0;

  localparam logic [1:0] REG_A1 = 2'd0;
  localparam logic [1:0] REG_A2 = 2'd1;
  localparam logic [1:0] REG_A3 = 2'd2;
  localparam logic [1:0] REG_A4 = 2'd3;

endpackage

// File: rtl/vec_wb_delay.sv
// Variable-depth (0..4) delay line for write-back beats.
// Carries {valid, idx, sel}; idx/sel hold their last written value.
module vec_wb_delay (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic [2:0] depth_i,
  input  logic       valid_i,
  input  logic [3:0] idx_i,
  input  logic [1:0] sel_i,
  output logic       valid_o,
  output logic [3:0] idx_o,
  output logic [1:0] sel_o
);

  logic [3:0]      v_q;
  logic [3:0][3:0] idx_q;
  logic [3:0][1:0] sel_q;
  logic [3:0]      hidx_q;
  logic [1:0]      hsel_q;
  logic            tap_v;
  logic [3:0]      tap_idx;
  logic [1:0]      tap_sel;

  // Shift every cycle; stage n holds the beat issued n+1 cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      idx_q <= '0;
      sel_q <= '0;
    end else if (clear_i) begin
      v_q   <= '0;
      idx_q <= '0;
      sel_q <= '0;
    end else begin
      v_q   <= {v_q[2:0], valid_i};
      idx_q <= {idx_q[2:0], idx_i};
      sel_q <= {sel_q[2:0], sel_i};
    end
  end

  // Pick the stage matching the requested depth; depth 0 is pass-through.
  always_comb begin
    tap_v   = valid_i;
    tap_idx = idx_i;
    tap_sel = sel_i;
    unique case (depth_i)
      3'd1: begin
        tap_v   = v_q[0];
        tap_idx = idx_q[0];
        tap_sel = sel_q[0];
      end
      3'd2: begin
        tap_v   = v_q[1];
        tap_idx = idx_q[1];
        tap_sel = sel_q[1];
      end
      3'd3: begin
        tap_v   = v_q[2];
        tap_idx = idx_q[2];
        tap_sel = sel_q[2];
      end
      3'd4: begin
        tap_v   = v_q[3];
        tap_idx = idx_q[3];
        tap_sel = sel_q[3];
      end
      default: begin
        tap_v   = valid_i;
        tap_idx = idx_i;
        tap_sel = sel_i;
      end
    endcase
  end

  // Remember the last write target so idle outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hidx_q <= '0;
      hsel_q <= '0;
    end else if (tap_v) begin
      hidx_q <= tap_idx;
      hsel_q <= tap_sel;
    end
  end

  assign valid_o = tap_v;
  assign idx_o   = tap_v ? tap_idx : hidx_q;
  assign sel_o   = tap_v ? tap_sel : hsel_q;

endmodule

// File: rtl/vec_sequencer.sv
// Vector micro-op sequencer: expands one instruction into
// per-element beats for memory, register file and ALU lanes.
module vec_sequencer
  import vec_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int MEM_AW  = 9,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [8:0]        instr,
  output logic              instr_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [1:0]        rd_sel,
  output logic [3:0]        rd_idx,
  output logic              alu_go,
  output logic              alu_mul,
  output logic              wb_we,
  output logic [1:0]        wb_sel,
  output logic [3:0]        wb_idx,
  output logic              done,
  output logic              busy
);

  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [1:0]    reg_q, reg_d;
  logic [4:0]    blk_q, blk_d;
  logic [IW-1:0] cnt_q, cnt_d;

  logic       hs;
  logic       issue;
  logic       last;
  logic       wb_v_in;
  logic [1:0] wb_sel_in;
  logic       wb_last;
  logic [2:0] depth;

  assign hs    = instr_valid && (state_q == S_IDLE);
  assign issue = (state_q == S_LOAD) || (state_q == S_STORE)
              || (state_q == S_ALU);
  assign last  = (cnt_q == LAST);

  // Write-back latency for the instruction in flight.
  always_comb begin
    depth = 3'd0;
    unique case (op_q)
      OP_LOAD: depth = 3'd1;
      OP_MUL:  depth = 3'(MUL_LAT);
      default: depth = 3'd0;
    endcase
  end

  // FSM and operand latching; beat counter parks on the last element.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    reg_d   = reg_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d  = op_e'(instr[OP_HI:OP_LO]);
          cnt_d = '0;
          unique case (op_d)
            OP_LOAD, OP_STORE: begin
              state_d = (op_d == OP_LOAD) ? S_LOAD : S_STORE;
              reg_d   = instr[REG_HI:REG_LO];
              blk_d   = instr[BLK_HI:BLK_LO];
            end
            default: state_d = S_ALU;
          endcase
        end
      end
      S_LOAD, S_STORE, S_ALU: begin
        if (last) begin
          state_d = (depth != 3'd0) ? S_DRAIN : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (wb_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      reg_q   <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_v_in   = issue && (op_q != OP_STORE);
  assign wb_sel_in = (op_q == OP_LOAD) ? reg_q : REG_A3;

  vec_wb_delay u_wb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (hs),
    .depth_i (depth),
    .valid_i (wb_v_in),
    .idx_i   (cnt_q),
    .sel_i   (wb_sel_in),
    .valid_o (wb_we),
    .idx_o   (wb_idx),
    .sel_o   (wb_sel)
  );

  assign wb_last = wb_we && (wb_idx == LAST);

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = !instr_ready;
  assign mem_addr    = MEM_AW'({blk_q, {IW{1'b0}}}) + MEM_AW'(cnt_q);
  assign mem_re      = (state_q == S_LOAD);
  assign mem_we      = (state_q == S_STORE);
  assign alu_go      = (state_q == S_ALU);
  assign alu_mul     = (op_q == OP_MUL);
  assign rd_sel      = reg_q;
  assign rd_idx      = cnt_q;
  assign done        = wb_last || ((state_q == S_STORE) && last);

endmodule

// File: doc/vec_sequencer.md
# vec_sequencer

Micro-op sequencer for the vector unit: accepts 9-bit vector instructions over a valid/ready handshake and expands each one into 16 per-element control beats. These beats drive the 32-bit memory port, the vector register file (A1..A4, 16 x 32-bit elements each) and the add/multiply lanes. It sits between the instruction source and the vector datapath inside `CPU` and owns all element counting and write-back timing; the datapath itself holds no sequencing state.

## Interface
- `LANES`, 16, elements per vector register; power of two.
- `MEM_AW`, 9, memory word-address width (512 words).
- `MUL_LAT`, 2, multiplier pipeline latency in cycles; legal range 1..4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction is offered.
- `instr` in 9: `[8:7]` opcode, `[6:5]` register select, `[4:0]` block number.
- `instr_ready` out 1: sequencer accepts an instruction this cycle.
- `mem_addr` out `MEM_AW`: word address of the current beat.
- `mem_re` out 1: memory read strobe; data returns one cycle later.
- `mem_we` out 1: memory write strobe; write data is the register-file read port at `rd_idx`.
- `rd_sel` out 2: register-file read register, for STORE.
- `rd_idx` out 4: element index for the register-file read and for ALU operands.
- `alu_go` out 1: ALU beat valid; operands are A1[`rd_idx`] and A2[`rd_idx`].
- `alu_mul` out 1: 1 = multiply, 0 = add; held for the whole instruction.
- `wb_we` out 1: register-file write strobe.
- `wb_sel` out 2: write target. LOAD writes its selected register; ALU writes the 64-bit result as {A4,A3}.
- `wb_idx` out 4: element index being written.
- `done` out 1: one-cycle pulse in the cycle of the instruction's last write.
- `busy` out 1: high from the accept edge until the cycle after `done`.

## Operation
- Opcodes:
  - 00 LOAD `reg` ← mem[`block`*16 +: 16].
  - 01 STORE mem[`block`*16 +: 16] ← `reg`.
  - 10 ADD {A4,A3} ← sext(A1)+sext(A2).
  - 11 MUL {A4,A3} ← sext(A1)*sext(A2).
  - For ADD and MUL, bits [6:0] are ignored.
- Base address is {`block`, 4'b0000`}`. The beat address is base + `rd_idx` in `MEM_AW` bits; no wrap beyond the block can occur.
- States:
  - IDLE: `instr_ready`=1. A handshake goes to LOAD, STORE or ALU according to the opcode and latches opcode, `reg` and `block`.
  - LOAD, STORE, ALU: issue one beat per cycle with `rd_idx` 0..15. After beat 15, go to DRAIN if write-backs are pending, otherwise to IDLE.
  - DRAIN: no issue; wait for the delay line to empty, then go to IDLE.
- Write-back delay D:
  - LOAD: D = 1.
  - STORE: no write-back; `done` is asserted with beat 15.
  - ADD: D = 0.
  - MUL: D = `MUL_LAT`.
  - `wb_we`/`wb_idx` are the issue-beat strobe/index delayed by D cycles.
- `instr_ready` is low in every state except IDLE. While busy, instructions are held off, never dropped. No overlap between instructions, so no hazard checks are needed.
- When `instr_valid` is low in IDLE, all strobes are 0 and outputs hold their last non-strobe values.
- Reset values: state IDLE, `instr_ready`=1, and every other output 0.
- An asynchronous reset mid-instruction abandons it immediately. The delay line is cleared, so no `wb_we` or `done` appears after reset release.

## Timing
- Handshake at edge E0. Beat k (k = 0..15) is presented in cycle E0+1+k.
- LOAD: `mem_re` in cycles 1..16; `wb_we` in cycles 2..17; `done` in cycle 17; `instr_ready` high again in cycle 18.
- STORE: `mem_we` in cycles 1..16; `done` in cycle 16; ready in cycle 17.
- ADD: `alu_go` and `wb_we` in cycles 1..16; `done` in cycle 16.
- MUL: `alu_go` in cycles 1..16; `wb_we` in cycles 1+`MUL_LAT`..16+`MUL_LAT`.
- Back-to-back: an instruction held valid is accepted in the first IDLE cycle. With a valid source this gives a throughput of 1 instruction per 16+D+1 cycles.
- `instr` is sampled only at the handshake edge; changes at other times have no effect.

## Structure
- Package `vec_pkg` holds:
  - the opcode enum (OP_LOAD, OP_STORE, OP_ADD, OP_MUL);
  - the state enum;
  - `instr` field bit positions;
  - register codes A1..A4 = 0..3.
- Sub-module `vec_wb_delay`: a variable-depth (0..4) shift register carrying {valid, idx, sel}. It is reset asynchronously and has a clear input.

## Test plan
- Reset, then LOAD `9'b000100001` → `mem_addr` 16..31 with `mem_re` in cycles 1..16; `wb_sel`=1, `wb_idx` 0..15 in cycles 2..17; `done` at cycle 17.
- STORE `9'b011000010` → `mem_we` with `mem_addr` 32..47, `rd_sel`=2, `rd_idx` 0..15; `done` at cycle 16; no `wb_we`.
- MUL with `MUL_LAT`=2 → `alu_go` in cycles 1..16, `alu_mul`=1; `wb_we` in cycles 3..18, `wb_sel`=2; `done` at cycle 18.
- ADD offered while a LOAD is in progress (valid held) → stalls with `instr_ready`=0; accepted in the cycle after LOAD `done`; no beat lost or duplicated.
- `rst_n` pulsed low mid-MUL at beat 7 → all outputs 0 asynchronously; after release `instr_ready`=1 and no stray `wb_we`/`done`.
- Full sequence LOAD, LOAD, MUL, STORE, STORE against a memory model → {A4,A3} matches the sign-extended products for all 16 elements.
